// File: rtl/psram_responder.sv
// QPI PSRAM device model: oversamples CS#/SCLK/SIO in the system clock domain and serves
// SPI 35H and QPI 38H/EBH/F5H from an internal byte memory.
module psram_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_psram_csn,
  input  logic       i_psram_sclk,
  input  logic [3:0] i_sio,
  output logic [3:0] o_sio,
  output logic       o_sio_oe,
  output logic       o_qpi,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SPI_CMD = 4'd1,
    ST_QPI_CMD = 4'd2,
    ST_ADDR    = 4'd3,
    ST_WAIT    = 4'd4,
    ST_RDATA   = 4'd5,
    ST_WDATA   = 4'd6,
    ST_IGNORE  = 4'd7
  } state_t;

  localparam int MEM_DEPTH = 1 << ADDR_BITS;
  localparam int CW        = 8;
  localparam logic [CW-1:0] WAIT_N = CW'(WAIT_CYCLES);

  logic                 csn_m_r, csn_s_r, csn_q_r;
  logic                 sclk_m_r, sclk_s_r, sclk_q_r;
  logic [3:0]           sio_m_r, sio_s_r;

  state_t               state_r, state_nxt;
  logic                 qpi_r, qpi_nxt;
  logic [7:0]           cmd_r, cmd_nxt;
  logic [CW-1:0]        cnt_r, cnt_nxt, cnt_inc_s;
  logic [ADDR_BITS-1:0] addr_r, addr_nxt, addr_inc_s;
  logic [3:0]           nib_r, nib_nxt;
  logic                 half_r, half_nxt;
  logic [3:0]           sio_r, sio_nxt;
  logic                 oe_r, oe_nxt;

  logic                 rise_s, fall_s, cs_start_s, cs_end_s;
  logic                 we_s;
  logic [7:0]           wdata_s, rd_byte_s;
  logic [7:0]           mem [MEM_DEPTH];

  // Two-flop synchronizers plus one extra stage for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csn_m_r  <= 1'b1;
      csn_s_r  <= 1'b1;
      csn_q_r  <= 1'b1;
      sclk_m_r <= 1'b0;
      sclk_s_r <= 1'b0;
      sclk_q_r <= 1'b0;
      sio_m_r  <= 4'h0;
      sio_s_r  <= 4'h0;
    end else begin
      csn_m_r  <= i_psram_csn;
      csn_s_r  <= csn_m_r;
      csn_q_r  <= csn_s_r;
      sclk_m_r <= i_psram_sclk;
      sclk_s_r <= sclk_m_r;
      sclk_q_r <= sclk_s_r;
      sio_m_r  <= i_sio;
      sio_s_r  <= sio_m_r;
    end
  end

  // SCLK edges only count while selected, so a rise coincident with cs_end is dropped.
  assign rise_s     = sclk_s_r & ~sclk_q_r & ~csn_s_r;
  assign fall_s     = ~sclk_s_r & sclk_q_r & ~csn_s_r;
  assign cs_start_s = ~csn_s_r & csn_q_r;
  assign cs_end_s   = csn_s_r & ~csn_q_r;

  assign cnt_inc_s  = (cnt_r == {CW{1'b1}}) ? cnt_r : cnt_r + CW'(1);
  assign addr_inc_s = addr_r + ADDR_BITS'(1);
  assign rd_byte_s  = mem[addr_r];
  assign wdata_s    = {nib_r, sio_s_r};

  // Next-state and datapath decode for the protocol FSM.
  always_comb begin
    state_nxt = state_r;
    qpi_nxt   = qpi_r;
    cmd_nxt   = cmd_r;
    cnt_nxt   = cnt_r;
    addr_nxt  = addr_r;
    nib_nxt   = nib_r;
    half_nxt  = half_r;
    sio_nxt   = sio_r;
    oe_nxt    = oe_r;
    we_s      = 1'b0;
    if (cs_end_s) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
      half_nxt  = 1'b0;
      cnt_nxt   = {CW{1'b0}};
      // Mode changes need the exact edge count; extra edges in IGNORE keep counting.
      if (!qpi_r && cmd_r == 8'h35 && cnt_r == CW'(8)) begin
        qpi_nxt = 1'b1;
      end else if (qpi_r && cmd_r == 8'hF5 && cnt_r == CW'(2)) begin
        qpi_nxt = 1'b0;
      end else begin
        qpi_nxt = qpi_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cs_start_s) begin
            state_nxt = qpi_r ? ST_QPI_CMD : ST_SPI_CMD;
            cnt_nxt   = {CW{1'b0}};
            cmd_nxt   = 8'h00;
            half_nxt  = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_SPI_CMD: begin
          if (rise_s) begin
            cmd_nxt   = {cmd_r[6:0], sio_s_r[0]};
            cnt_nxt   = cnt_inc_s;
            state_nxt = (cnt_r == CW'(7)) ? ST_IGNORE : ST_SPI_CMD;
          end else begin
            state_nxt = ST_SPI_CMD;
          end
        end
        ST_QPI_CMD: begin
          if (rise_s) begin
            cmd_nxt = {cmd_r[3:0], sio_s_r};
            cnt_nxt = cnt_inc_s;
            if (cnt_r == CW'(1)) begin
              if ({cmd_r[3:0], sio_s_r} == 8'h38 || {cmd_r[3:0], sio_s_r} == 8'hEB) begin
                state_nxt = ST_ADDR;
                cnt_nxt   = {CW{1'b0}};
              end else begin
                state_nxt = ST_IGNORE;
              end
            end else begin
              state_nxt = ST_QPI_CMD;
            end
          end else begin
            state_nxt = ST_QPI_CMD;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            addr_nxt = ADDR_BITS'({addr_r, sio_s_r});
            cnt_nxt  = cnt_inc_s;
            if (cnt_r == CW'(5)) begin
              cnt_nxt  = {CW{1'b0}};
              half_nxt = 1'b0;
              if (cmd_r == 8'h38) begin
                state_nxt = ST_WDATA;
              end else if (WAIT_CYCLES == 0) begin
                state_nxt = ST_RDATA;
              end else begin
                state_nxt = ST_WAIT;
              end
            end else begin
              state_nxt = ST_ADDR;
            end
          end else begin
            state_nxt = ST_ADDR;
          end
        end
        ST_WAIT: begin
          if (rise_s) begin
            cnt_nxt   = cnt_inc_s;
            state_nxt = (cnt_inc_s == WAIT_N) ? ST_RDATA : ST_WAIT;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_RDATA: begin
          if (fall_s) begin
            oe_nxt = 1'b1;
            if (!half_r) begin
              sio_nxt  = rd_byte_s[7:4];
              half_nxt = 1'b1;
            end else begin
              sio_nxt  = rd_byte_s[3:0];
              half_nxt = 1'b0;
              addr_nxt = addr_inc_s;
            end
          end else begin
            oe_nxt = oe_r;
          end
        end
        ST_WDATA: begin
          if (rise_s) begin
            if (!half_r) begin
              nib_nxt  = sio_s_r;
              half_nxt = 1'b1;
            end else begin
              we_s     = 1'b1;
              addr_nxt = addr_inc_s;
              half_nxt = 1'b0;
            end
          end else begin
            half_nxt = half_r;
          end
        end
        ST_IGNORE: begin
          if (rise_s) begin
            cnt_nxt = cnt_inc_s;
          end else begin
            cnt_nxt = cnt_r;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      qpi_r   <= 1'b0;
      cmd_r   <= 8'h00;
      cnt_r   <= {CW{1'b0}};
      addr_r  <= {ADDR_BITS{1'b0}};
      nib_r   <= 4'h0;
      half_r  <= 1'b0;
      sio_r   <= 4'h0;
      oe_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      qpi_r   <= qpi_nxt;
      cmd_r   <= cmd_nxt;
      cnt_r   <= cnt_nxt;
      addr_r  <= addr_nxt;
      nib_r   <= nib_nxt;
      half_r  <= half_nxt;
      sio_r   <= sio_nxt;
      oe_r    <= oe_nxt;
    end
  end

  // Byte memory: deliberately unreset so contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (we_s) begin
      mem[addr_r] <= wdata_s;
    end
  end

  assign o_sio    = sio_r;
  assign o_sio_oe = oe_r;
  assign o_qpi    = qpi_r;
  assign o_state  = state_r;

endmodule

// File: tb/tb_psram_responder.sv
// Bench for psram_responder: acts as the PSRAM controller, checks mode handling from a
// vector table and read data against a scoreboard fed from a byte-level memory model.
module tb_psram_responder;

  localparam int ADDR_BITS   = 10;
  localparam int WAIT_CYCLES = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       csn;
  logic       sclk;
  logic [3:0] sio;
  logic [3:0] o_sio;
  logic       o_sio_oe;
  logic       o_qpi;
  logic [3:0] o_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [1024];
  logic [3:0] sb [$];

  typedef struct {
    bit          qpi_frame;
    logic [15:0] bits;
    int          count;
    logic        exp_qpi;
  } mode_vec_t;

  mode_vec_t vecs [9];

  psram_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_psram_csn (csn),
    .i_psram_sclk(sclk),
    .i_sio       (sio),
    .o_sio       (o_sio),
    .o_sio_oe    (o_sio_oe),
    .o_qpi       (o_qpi),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One SCLK pulse carrying nibble d; leaves SCLK low.
  task automatic clk_nib(input logic [3:0] d);
    sio = d;
    tick(4);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic end_txn();
    tick(4);
    csn = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input bit qf, input logic [15:0] bits, input int count);
    csn = 1'b0;
    tick(4);
    for (int i = 0; i < count; i++) begin
      if (qf) clk_nib(bits[15-4*i -: 4]);
      else    clk_nib({3'b000, bits[15-i]});
    end
    end_txn();
  endtask

  task automatic qpi_write(input logic [23:0] a, input logic [31:0] d, input int nnib);
    logic [9:0] ix;
    csn = 1'b0;
    tick(4);
    clk_nib(4'h3);
    clk_nib(4'h8);
    for (int i = 0; i < 6; i++) clk_nib(a[23-4*i -: 4]);
    for (int i = 0; i < nnib; i++) clk_nib(d[31-4*i -: 4]);
    end_txn();
    for (int j = 0; j < nnib / 2; j++) begin
      ix = a[9:0] + 10'(j);
      mdl[ix] = d[31-8*j -: 8];
    end
  endtask

  task automatic qpi_read(input logic [23:0] a, input int nbytes, input bit rst_mid);
    logic [9:0] ix;
    logic [7:0] b;
    logic [3:0] exp_n;
    for (int j = 0; j < nbytes; j++) begin
      ix = a[9:0] + 10'(j);
      b  = mdl[ix];
      sb.push_back(b[7:4]);
      sb.push_back(b[3:0]);
    end
    csn = 1'b0;
    tick(4);
    clk_nib(4'hE);
    clk_nib(4'hB);
    for (int i = 0; i < 6; i++) clk_nib(a[23-4*i -: 4]);
    for (int i = 0; i < WAIT_CYCLES; i++) begin
      tick(4);
      sclk = 1'b1;
      if (i < WAIT_CYCLES - 1) begin
        tick(4);
        sclk = 1'b0;
      end
    end
    tick(4);
    chk("wait_state", {28'h0, o_state}, 32'h5);
    chk("wait_oe", {31'h0, o_sio_oe}, 32'h0);
    for (int k = 0; k < 2 * nbytes; k++) begin
      sclk = 1'b0;
      tick(4);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=empty expected=entry");
      end else begin
        exp_n = sb.pop_front();
        chk("rd_nibble", {27'h0, o_sio_oe, o_sio}, {27'h0, 1'b1, exp_n});
      end
      sclk = 1'b1;
      tick(4);
    end
    if (rst_mid) begin
      chk("pre_rst_state", {28'h0, o_state}, 32'h5);
      rst = 1'b1;
      #1;
      chk("rst_mid_out", {25'h0, o_sio_oe, o_qpi, o_sio, o_state}, 32'h0);
      csn  = 1'b1;
      sclk = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(4);
    end else begin
      csn = 1'b1;
      tick(3);
      chk("cs_end_oe", {31'h0, o_sio_oe}, 32'h0);
      tick(2);
      sclk = 1'b0;
      tick(4);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h3400, 8, 1'b0};
    vecs[1] = '{1'b0, 16'h3500, 7, 1'b0};
    vecs[2] = '{1'b0, 16'h3500, 9, 1'b0};
    vecs[3] = '{1'b0, 16'h3500, 8, 1'b1};
    vecs[4] = '{1'b1, 16'hF500, 1, 1'b1};
    vecs[5] = '{1'b1, 16'h1200, 2, 1'b1};
    vecs[6] = '{1'b1, 16'hF500, 3, 1'b1};
    vecs[7] = '{1'b1, 16'hF500, 2, 1'b0};
    vecs[8] = '{1'b0, 16'h3500, 8, 1'b1};

    rst  = 1'b1;
    csn  = 1'b1;
    sclk = 1'b0;
    sio  = 4'h0;
    tick(3);
    chk("reset_out", {25'h0, o_sio_oe, o_qpi, o_sio, o_state}, 32'h0);
    rst = 1'b0;
    tick(3);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].qpi_frame, vecs[v].bits, vecs[v].count);
      chk("mode_qpi", {31'h0, o_qpi}, {31'h0, vecs[v].exp_qpi});
      chk("mode_idle", {27'h0, o_sio_oe, o_state}, 32'h0);
    end

    qpi_write(24'h000010, 32'hA53C0000, 4);
    qpi_read(24'h000010, 2, 1'b0);

    qpi_write(24'h0003FF, 32'h11220000, 4);
    qpi_read(24'h0403FF, 2, 1'b0);

    qpi_write(24'h000020, 32'h77000000, 2);
    qpi_write(24'h000020, 32'h10000000, 1);
    qpi_read(24'h000020, 1, 1'b0);

    qpi_read(24'h000010, 1, 1'b1);
    send_frame(1'b0, 16'h3500, 8);
    chk("reenter_qpi", {31'h0, o_qpi}, 32'h1);
    qpi_read(24'h000010, 2, 1'b0);

    chk("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
